// File: rtl/led_pkg.sv
// Shared definitions for the key/LED front end: LED mode encoding and
// a ceiling-log2 helper used to size the debounce and blink counters.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STEADY = 2'd1,
        MODE_SLOW   = 2'd2,
        MODE_FAST   = 2'd3
    } led_mode_e;

    // Bits needed to hold 0..value-1; never less than 1 so tiny counts still get a flop.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single key channel: 2-flop synchroniser, debounce counter, stable level
// register and a one-cycle pulse on an accepted press (stable 1 -> 0).
module key_debounce
    import led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 2560
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic stable_o,
    output logic flag_o
);

    localparam int unsigned    CW       = clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          flag_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count while the synced level disagrees with the stable level; any agreement clears.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounce state and press pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
        end else begin
            sync1_q  <= key_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            flag_q   <= stable_q & ~stable_d;
        end
    end

    assign stable_o = stable_q;
    assign flag_o   = flag_q;

endmodule

// File: rtl/key_led_ctrl.sv
// Key/LED front end: NUM_KEYS debounced channels, LED mode FSM driven by
// ch0 (on/off) and ch1 (mode step), and a blink generator for the LED.
module key_led_ctrl
    import led_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = 2,
    parameter int unsigned DEBOUNCE_CYC   = 2560,
    parameter int unsigned BLINK_HALF     = 32000,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_stable,
    output logic [NUM_KEYS-1:0] key_flag,
    output logic [1:0]          led_mode,
    output logic                led
);

    localparam int unsigned   BW        = clog2(BLINK_HALF);
    localparam logic [BW-1:0] SLOW_LAST = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] FAST_LAST = BW'(BLINK_HALF / 4 - 1);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_i   (key[i]),
            .stable_o(key_stable[i]),
            .flag_o  (key_flag[i])
        );
    end

    led_mode_e     mode_q, mode_d;
    logic [BW-1:0] blink_cnt_q;
    logic [BW-1:0] half_last;
    logic          led_q;

    // Next mode: ch0 has priority and toggles OFF/on; ch1 steps the on-modes only.
    always_comb begin
        mode_d = mode_q;
        if (key_flag[0]) begin
            mode_d = (mode_q == MODE_OFF) ? MODE_STEADY : MODE_OFF;
        end else if (key_flag[1]) begin
            case (mode_q)
                MODE_STEADY: mode_d = MODE_SLOW;
                MODE_SLOW:   mode_d = MODE_FAST;
                MODE_FAST:   mode_d = MODE_STEADY;
                default:     mode_d = MODE_OFF;
            endcase
        end
    end

    // Last blink count for the mode being entered or held.
    always_comb begin
        half_last = (mode_d == MODE_FAST) ? FAST_LAST : SLOW_LAST;
    end

    // Mode register, blink counter and logical LED, all registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_OFF;
            blink_cnt_q <= '0;
            led_q       <= 1'b0;
        end else begin
            mode_q <= mode_d;
            case (mode_d)
                MODE_OFF: begin
                    blink_cnt_q <= '0;
                    led_q       <= 1'b0;
                end
                MODE_STEADY: begin
                    blink_cnt_q <= '0;
                    led_q       <= 1'b1;
                end
                default: begin
                    if (mode_d != mode_q) begin
                        blink_cnt_q <= '0;
                        led_q       <= 1'b1;
                    end else if (blink_cnt_q == half_last) begin
                        blink_cnt_q <= '0;
                        led_q       <= ~led_q;
                    end else begin
                        blink_cnt_q <= blink_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign led_mode = mode_q;
    assign led      = led_q ^ LED_ACTIVE_LOW;

endmodule

// File: doc/key_led_ctrl.md
Name: key_led_ctrl

Overview:
- Parametrised successor to the two-key LED front end.
- Debounces NUM_KEYS raw active-low key inputs with a common configurable debounce time.
- Publishes per-channel stable levels and press pulses.
- Drives one LED through an OFF / STEADY / BLINK_SLOW / BLINK_FAST state machine with a fixed key priority.
- Sits directly behind the pads on the on-chip 128 kHz RC clock; channels 2 and up are debounced for other consumers only.

Parameters:
NUM_KEYS, 2, number of key channels (legal range 2..8)
DEBOUNCE_CYC, 2560, cycles a synced level must hold before acceptance (20 ms at 128 kHz; legal range 2..65535)
BLINK_HALF, 32000, half-period in cycles for BLINK_SLOW (250 ms); BLINK_FAST uses BLINK_HALF/4 (legal range 4..2^20)
LED_ACTIVE_LOW, 0, 1 inverts the led pin polarity

Ports:
clk  in  1  system clock, 128 kHz RC
rst_n  in  1  asynchronous active-low reset
key  in  NUM_KEYS  raw key inputs, active-low (0 = pressed), asynchronous to clk
key_stable  out  NUM_KEYS  debounced level per channel, 1 = released
key_flag  out  NUM_KEYS  one-cycle pulse on accepted press (stable 1->0)
led_mode  out  2  current state: 0 OFF, 1 STEADY, 2 BLINK_SLOW, 3 BLINK_FAST
led  out  1  LED drive, polarity per LED_ACTIVE_LOW

Behaviour:
- Reset is asynchronous and active-low on rst_n. It returns every flop to its reset value at once, with no clk needed.
- Reset values: key_stable all 1, key_flag all 0, synchroniser flops 1, debounce counters 0, led_mode OFF, blink counter 0, logical LED 0.
- Synchroniser: each key passes through 2 flops.
- Debounce counter, per channel:
  - When the synced value equals key_stable, the counter is cleared.
  - Otherwise the counter increments each cycle.
  - When the counter equals DEBOUNCE_CYC-1, key_stable takes the synced value and the counter clears.
  - A bounce back to the stable value before then clears the counter, so there is no partial credit.
- Latency: a clean pin edge reaches key_stable 2+DEBOUNCE_CYC cycles later.
- key_flag[i] is high for exactly the one cycle after key_stable[i] falls. Releases produce no flag.
- Counter width is clog2(DEBOUNCE_CYC). The counter never wraps, because it compares before incrementing.
- Mode FSM, evaluated on key_flag:
  - ch0 press, from OFF: go to STEADY.
  - ch0 press, from any other state: go to OFF.
  - ch1 press, in OFF: ignored.
  - ch1 press, otherwise: STEADY -> BLINK_SLOW -> BLINK_FAST -> STEADY.
  - Simultaneous ch0 and ch1 flags in one cycle: ch0 is acted on and ch1 is discarded.
  - Channels 2 and up have no effect on the FSM.
- Blink:
  - The counter clears, and the logical LED is forced to 1, on every state change into BLINK_SLOW or BLINK_FAST.
  - In a blink state the counter runs 0..H-1, where H = BLINK_HALF (slow) or BLINK_HALF/4 (fast).
  - At H-1 the logical LED toggles and the counter clears.
- LED per state: logical LED is 0 in OFF and 1 in STEADY; the blink counter is held at 0 in both.
- led_mode and the LED update in the cycle after the key_flag pulse, i.e. one registered stage.
- led = logical LED XOR LED_ACTIVE_LOW.
- Reset mid-blink or mid-debounce: all state is lost immediately and no flag is emitted on reset release. A key held through reset release is seen as pressed after 2+DEBOUNCE_CYC cycles and generates a flag then.

Decomposition:
- Shared package led_pkg holds:
  - the led_mode encoding constants (MODE_OFF=0, MODE_STEADY=1, MODE_SLOW=2, MODE_FAST=3);
  - a clog2 function for counter widths.
- One sub-module, key_debounce: single channel, covering the synchroniser, debounce counter, stable register and press pulse, parametrised by DEBOUNCE_CYC. It is instantiated NUM_KEYS times in a generate loop.
- The mode FSM and blink counter live in the top level.

Test Plan:
All scenarios use NUM_KEYS=3, DEBOUNCE_CYC=4, BLINK_HALF=8.
- Reset: hold rst_n=0 with key=3'b000 -> key_stable=3'b111, key_flag=0, led_mode=0, led=0. Release and hold key=000 -> key_stable falls to 0 six cycles after release, with a flag on all three channels.
- Bounce: drive key0 low for 3 cycles, high for 1, then low steadily -> no flag from the 3-cycle pulse; key_flag[0] fires exactly 6 cycles after the final falling edge, then led_mode=1 and led=1.
- Mode cycle: from STEADY, press ch1 three times -> led_mode goes 2, 3, 1. In mode 2 led toggles every 8 cycles starting high; in mode 3 it toggles every 2 cycles.
- Priority: with led_mode=2, release ch0 and ch1 together into a clean press -> same-cycle flags; led_mode=0 and led=0, ch1 ignored. Then press ch1 alone -> led_mode stays 0.
- Ch2 isolation: press and release ch2 -> key_flag[2] pulses once and key_stable[2] follows; led_mode is unchanged.
- Polarity and mid-op reset: with LED_ACTIVE_LOW=1 in STEADY -> led=0. Assert rst_n mid-blink -> led=1 (logical 0) and led_mode=0 asynchronously, without waiting for a clk edge.
